fifo_burst_reader: RTL and testbench

Drains a 32-bit prefetch (show-ahead) FIFO on its read side and turns the stream into fixed-length address-stamped write bursts for the downstream memory write master. Words are staged locally until a whole burst is held, then a burst request with address and length is issued. After the request is acknowledged, the staged words stream out on a valid/ready data channel. The block sits in the read-clock domain, directly behind the FIFO's `rd_en`/`rd_vld`/`rd_data` port.

---
 rtl/fifo_burst_pkg.sv | 20 ++
 rtl/burst_stage_buf.sv | 23 ++
 rtl/fifo_burst_reader.sv | 147 ++++++++++++++
 tb/tb_fifo_burst_reader.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_burst_pkg.sv
// Shared types and constants for the FIFO-to-burst reader.
package fifo_burst_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        REQ  = 2'd2,
        SEND = 2'd3
    } fbr_state_t;

    localparam int BURST_LEN_DEF   = 16;
    localparam int DATA_WIDTH_DEF  = 32;
    localparam int BYTES_PER_BURST = BURST_LEN_DEF * DATA_WIDTH_DEF / 8;
    localparam int LEN_W           = 7;

    function automatic logic [31:0] burst_bytes(input logic [LEN_W-1:0] len, input int data_width);
        return 32'(len) * 32'(data_width / 8);
    endfunction

endpackage

// File: rtl/burst_stage_buf.sv
// Staging register array: one write port, one asynchronous read port, no reset on data.
module burst_stage_buf #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int IDX_W      = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [IDX_W-1:0]      rd_idx,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_idx] <= wr_data;
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/fifo_burst_reader.sv
// Drains a show-ahead FIFO into fixed-length address-stamped write bursts.
// Optional partial-burst close via the flush port when FIFO_BURST_FLUSH_EN is defined.
module fifo_burst_reader
    import fifo_burst_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int BURST_LEN  = BURST_LEN_DEF,
    parameter int ADDR_WIDTH = 28
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst,
    output logic                  fifo_rd_en,
    input  logic                  fifo_rd_vld,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
    input  logic [15:0]           cfg_burst_num,
    output logic                  burst_req,
    input  logic                  burst_ack,
    output logic [ADDR_WIDTH-1:0] burst_addr,
    output logic [LEN_W-1:0]      burst_len,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic                  wdata_vld,
    input  logic                  wdata_rdy,
    output logic                  wdata_last,
    output logic                  frame_done
`ifdef FIFO_BURST_FLUSH_EN
    ,
    input  logic                  flush
`endif
);

    localparam int IDX_W = $clog2(BURST_LEN);

    fbr_state_t            state;
    logic [LEN_W-1:0]      wcnt;
    logic [LEN_W-1:0]      rcnt;
    logic [LEN_W-1:0]      len_q;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [15:0]           bursts_left;
    logic                  flushed;
    logic                  pop;
    logic                  full_pop;
    logic                  flush_go;
    logic                  wr_hs;
    logic                  last_hs;
    logic [DATA_WIDTH-1:0] stage_q;

    assign pop      = fifo_rd_en & fifo_rd_vld;
    assign full_pop = pop && (wcnt == LEN_W'(BURST_LEN - 1));
    assign wr_hs    = wdata_vld & wdata_rdy;
    assign last_hs  = wr_hs && (rcnt == len_q - LEN_W'(1));

`ifdef FIFO_BURST_FLUSH_EN
    assign flush_go = flush && (wcnt != '0);
`else
    assign flush_go = 1'b0;
`endif

    assign burst_addr = cur_addr;
    assign burst_len  = len_q;
    assign wdata      = wdata_vld ? stage_q : '0;
    assign wdata_last = wdata_vld && (rcnt == len_q - LEN_W'(1));

    burst_stage_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (BURST_LEN),
        .IDX_W      (IDX_W)
    ) u_stage (
        .clk     (rd_clk),
        .wr_en   (pop),
        .wr_idx  (wcnt[IDX_W-1:0]),
        .wr_data (fifo_rd_data),
        .rd_idx  (rcnt[IDX_W-1:0]),
        .rd_data (stage_q)
    );

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            state       <= IDLE;
            wcnt        <= '0;
            rcnt        <= '0;
            len_q       <= '0;
            cur_addr    <= '0;
            bursts_left <= '0;
            flushed     <= 1'b0;
            fifo_rd_en  <= 1'b0;
            burst_req   <= 1'b0;
            wdata_vld   <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (pop) wcnt <= wcnt + LEN_W'(1);
            case (state)
                IDLE: begin
                    cur_addr    <= cfg_base_addr;
                    bursts_left <= cfg_burst_num;
                    fifo_rd_en  <= 1'b1;
                    state       <= FILL;
                end
                FILL: begin
                    if (full_pop) begin
                        fifo_rd_en <= 1'b0;
                        burst_req  <= 1'b1;
                        len_q      <= LEN_W'(BURST_LEN);
                        state      <= REQ;
                    end else if (flush_go) begin
                        // A word popped in the flush cycle is already staged, so it joins the burst.
                        fifo_rd_en <= 1'b0;
                        burst_req  <= 1'b1;
                        len_q      <= wcnt + LEN_W'(pop);
                        flushed    <= 1'b1;
                        state      <= REQ;
                    end
                end
                REQ: begin
                    if (burst_ack) begin
                        burst_req <= 1'b0;
                        wdata_vld <= 1'b1;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    if (wr_hs) rcnt <= rcnt + LEN_W'(1);
                    if (last_hs) begin
                        wdata_vld  <= 1'b0;
                        rcnt       <= '0;
                        wcnt       <= '0;
                        flushed    <= 1'b0;
                        fifo_rd_en <= 1'b1;
                        state      <= FILL;
                        // Frame wrap is the only point where the cfg inputs are re-sampled.
                        if (bursts_left == 16'd1 || flushed) begin
                            frame_done  <= 1'b1;
                            cur_addr    <= cfg_base_addr;
                            bursts_left <= cfg_burst_num;
                        end else begin
                            cur_addr    <= cur_addr + ADDR_WIDTH'(burst_bytes(len_q, DATA_WIDTH));
                            bursts_left <= bursts_left - 16'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Scoreboard bench for fifo_burst_reader: directed bursts, backpressure, frame wrap, reset, optional flush.
module tb_fifo_burst_reader;

    localparam int DW = 32;
    localparam int AW = 28;
    localparam int BL = 16;

    logic          rd_clk = 1'b0;
    logic          rd_rst = 1'b0;
    logic          fifo_rd_en;
    logic          fifo_rd_vld;
    logic [DW-1:0] fifo_rd_data;
    logic [AW-1:0] cfg_base_addr;
    logic [15:0]   cfg_burst_num;
    logic          burst_req;
    logic          burst_ack;
    logic [AW-1:0] burst_addr;
    logic [6:0]    burst_len;
    logic [DW-1:0] wdata;
    logic          wdata_vld;
    logic          wdata_rdy;
    logic          wdata_last;
    logic          frame_done;
`ifdef FIFO_BURST_FLUSH_EN
    logic          flush;
`endif

    fifo_burst_reader dut (
        .rd_clk        (rd_clk),
        .rd_rst        (rd_rst),
        .fifo_rd_en    (fifo_rd_en),
        .fifo_rd_vld   (fifo_rd_vld),
        .fifo_rd_data  (fifo_rd_data),
        .cfg_base_addr (cfg_base_addr),
        .cfg_burst_num (cfg_burst_num),
        .burst_req     (burst_req),
        .burst_ack     (burst_ack),
        .burst_addr    (burst_addr),
        .burst_len     (burst_len),
        .wdata         (wdata),
        .wdata_vld     (wdata_vld),
        .wdata_rdy     (wdata_rdy),
        .wdata_last    (wdata_last),
        .frame_done    (frame_done)
`ifdef FIFO_BURST_FLUSH_EN
        ,
        .flush         (flush)
`endif
    );

    initial forever #5 rd_clk = ~rd_clk;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] fifo_q   [$];
    logic [AW-1:0] exp_addr [$];
    logic [6:0]    exp_len  [$];
    logic [DW-1:0] exp_wd   [$];
    logic          exp_last [$];

    int vld_mode   = 0;
    int rdy_mode   = 0;
    int ack_delay  = 0;
    bit ack_always = 1'b0;
    int fd_seen    = 0;
    int hs_total   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s: event occurred, none expected", name);
    endtask

    task automatic chk_zero(input string p);
        chk({p, "_rden"},  64'(fifo_rd_en), 64'd0);
        chk({p, "_req"},   64'(burst_req),  64'd0);
        chk({p, "_addr"},  64'(burst_addr), 64'd0);
        chk({p, "_len"},   64'(burst_len),  64'd0);
        chk({p, "_wdata"}, 64'(wdata),      64'd0);
        chk({p, "_wvld"},  64'(wdata_vld),  64'd0);
        chk({p, "_wlast"}, 64'(wdata_last), 64'd0);
        chk({p, "_fdone"}, 64'(frame_done), 64'd0);
    endtask

    // Expected request + data words; optionally load the FIFO model with the same words.
    task automatic load_burst(input logic [AW-1:0] addr, input int len, input int nexp,
                              input logic [DW-1:0] base, input int nfifo);
        exp_addr.push_back(addr);
        exp_len.push_back(7'(len));
        for (int i = 0; i < nexp; i++) begin
            exp_wd.push_back(base + DW'(i));
            exp_last.push_back(i == len - 1);
        end
        for (int i = 0; i < nfifo; i++) fifo_q.push_back(base + DW'(i));
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while ((exp_addr.size() != 0 || exp_wd.size() != 0 || fifo_q.size() != 0) && n < 3000) begin
            @(posedge rd_clk);
            n++;
        end
        if (n >= 3000) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: got %0d pending words, expected 0", name, exp_wd.size());
        end
        repeat (3) @(posedge rd_clk);
        #1;
    endtask

    // FIFO / acknowledge / ready driver
    int drv_cyc = 0;
    int ack_cnt = 0;
    bit do_pop  = 1'b0;
    bit tgl     = 1'b0;
    initial begin
        fifo_rd_vld  = 1'b0;
        fifo_rd_data = '0;
        burst_ack    = 1'b0;
        wdata_rdy    = 1'b0;
        forever begin
            @(negedge rd_clk);
            do_pop = fifo_rd_en && fifo_rd_vld && !rd_rst;
            @(posedge rd_clk);
            #1;
            if (do_pop && fifo_q.size() != 0) void'(fifo_q.pop_front());
            drv_cyc++;
            tgl = ~tgl;
            fifo_rd_vld  = (fifo_q.size() != 0) && (vld_mode == 0 || tgl);
            fifo_rd_data = fifo_rd_vld ? fifo_q[0] : (32'hBAD0_0000 + DW'(drv_cyc));
            wdata_rdy    = (rdy_mode == 0) ? 1'b1 : ((drv_cyc % 3) == 0);
            if (burst_req) begin
                ack_cnt++;
                burst_ack = (ack_cnt > ack_delay);
            end else begin
                ack_cnt   = 0;
                burst_ack = ack_always;
            end
        end
    end

    // Monitor: compares every handshake against the scoreboard queues.
    int            m_cyc = 0, m_last_pop = -100, m_ack_cyc = -100, m_lasths = -100, m_pops = 0;
    bit            m_prev_req = 0, m_prev_vld = 0, m_prev_rden = 0, m_hold_req = 0, m_hold_wd = 0;
    logic [AW-1:0] m_h_addr;
    logic [6:0]    m_h_len;
    logic [DW-1:0] m_h_wd;
    logic          m_h_last;
    initial begin
        forever begin
            @(negedge rd_clk);
            m_cyc++;
            if (rd_rst) begin
                m_prev_req = 0; m_prev_vld = 0; m_prev_rden = 0;
                m_hold_req = 0; m_hold_wd = 0; m_pops = 0;
                continue;
            end
            if (m_hold_req && burst_req) begin
                chk("req_addr_stable", 64'(burst_addr), 64'(m_h_addr));
                chk("req_len_stable",  64'(burst_len),  64'(m_h_len));
            end
            if (m_hold_wd && wdata_vld) begin
                chk("wdata_stable", 64'(wdata),      64'(m_h_wd));
                chk("wlast_stable", 64'(wdata_last), 64'(m_h_last));
            end
            if (burst_req && !m_prev_req && m_pops == BL)
                chk("pop_to_req_latency", 64'(m_cyc - m_last_pop), 64'd1);
            if (wdata_vld && !m_prev_vld)
                chk("ack_to_vld_latency", 64'(m_cyc - m_ack_cyc), 64'd1);
            if (fifo_rd_en && !m_prev_rden && m_lasths >= 0) begin
                chk("last_to_rden_latency", 64'(m_cyc - m_lasths), 64'd1);
                m_lasths = -100;
            end
            if (fifo_rd_en && fifo_rd_vld) begin
                m_pops++;
                m_last_pop = m_cyc;
            end
            if (burst_req && burst_ack) begin
                if (exp_addr.size() == 0) fail_now("unexpected_burst_req");
                else begin
                    chk("burst_addr", 64'(burst_addr), 64'(exp_addr[0]));
                    chk("burst_len",  64'(burst_len),  64'(exp_len[0]));
                    chk("pops_per_burst", 64'(m_pops), 64'(exp_len[0]));
                    void'(exp_addr.pop_front());
                    void'(exp_len.pop_front());
                end
                m_pops    = 0;
                m_ack_cyc = m_cyc;
            end
            if (wdata_vld && wdata_rdy) begin
                hs_total++;
                if (exp_wd.size() == 0) fail_now("unexpected_wdata");
                else begin
                    chk("wdata",      64'(wdata),      64'(exp_wd[0]));
                    chk("wdata_last", 64'(wdata_last), 64'(exp_last[0]));
                    void'(exp_wd.pop_front());
                    void'(exp_last.pop_front());
                end
                if (wdata_last) m_lasths = m_cyc;
            end
            if (frame_done) fd_seen++;
            m_hold_req  = burst_req && !burst_ack;
            m_h_addr    = burst_addr;
            m_h_len     = burst_len;
            m_hold_wd   = wdata_vld && !wdata_rdy;
            m_h_wd      = wdata;
            m_h_last    = wdata_last;
            m_prev_req  = burst_req;
            m_prev_vld  = wdata_vld;
            m_prev_rden = fifo_rd_en;
        end
    end

    initial begin
        int n;
        int hs_target;
`ifdef FIFO_BURST_FLUSH_EN
        flush = 1'b0;
`endif
        cfg_base_addr = 28'h100;
        cfg_burst_num = 16'd4;
        rd_rst = 1'b1;
        repeat (3) @(posedge rd_clk);
        #1;
        chk_zero("reset");
        rd_rst = 1'b0;
        @(posedge rd_clk);
        #1;
        chk("idle_exit_rden", 64'(fifo_rd_en), 64'd1);

        // Back-to-back words, ack immediately
        load_burst(28'h100, BL, BL, 32'h0, BL);
        wait_done("A");

        // Toggling FIFO valid, ack held high while no request
        vld_mode = 1; ack_always = 1'b1;
        load_burst(28'h140, BL, BL, 32'h20, BL);
        wait_done("B");
        vld_mode = 0; ack_always = 1'b0;

        // Ready every third cycle, delayed ack
        rdy_mode = 1; ack_delay = 2;
        load_burst(28'h180, BL, BL, 32'h30, BL);
        wait_done("C");
        rdy_mode = 0; ack_delay = 0;
        chk("fd_before_wrap", 64'(fd_seen), 64'd0);

        // Last burst of the 4-burst frame, then a 2-burst frame
        cfg_base_addr = 28'h100;
        cfg_burst_num = 16'd2;
        load_burst(28'h1C0, BL, BL, 32'h40, BL);
        wait_done("D0");
        chk("fd_after_frame1", 64'(fd_seen), 64'd1);
        load_burst(28'h100, BL, BL, 32'h50, BL);
        wait_done("D1");
        chk("fd_mid_frame2", 64'(fd_seen), 64'd1);
        load_burst(28'h140, BL, BL, 32'h60, BL);
        wait_done("D2");
        chk("fd_after_frame2", 64'(fd_seen), 64'd2);

        // Reset while the eighth word is on the bus
        hs_target = hs_total + 7;
        load_burst(28'h100, BL, 7, 32'h70, BL);
        n = 0;
        while (hs_total < hs_target && n < 2000) begin
            @(posedge rd_clk);
            n++;
        end
        if (n >= 2000) begin
            checks++; failures++;
            $display("FAIL rst_wait_timeout: got %0d handshakes, expected %0d", hs_total, hs_target);
        end
        #2 rd_rst = 1'b1;
        #1 chk_zero("midrst");
        chk("midrst_exp_drained", 64'(exp_wd.size()), 64'd0);
        fifo_q.delete();
        cfg_base_addr = 28'h300;
        cfg_burst_num = 16'd1;
        repeat (2) @(posedge rd_clk);
        #1;
        rd_rst = 1'b0;
        chk("post_rst_idle_rden", 64'(fifo_rd_en), 64'd0);
        @(posedge rd_clk);
        #1;
        chk("post_rst_fill_rden", 64'(fifo_rd_en), 64'd1);
        cfg_base_addr = 28'h400;
        cfg_burst_num = 16'd4;
        load_burst(28'h300, BL, BL, 32'h80, BL);
        wait_done("E");
        chk("fd_after_rst_frame", 64'(fd_seen), 64'd3);

`ifdef FIFO_BURST_FLUSH_EN
        // Five words then flush closes a partial, frame-ending burst
        load_burst(28'h400, 5, 5, 32'h90, 5);
        n = 0;
        while (fifo_q.size() != 0 && n < 500) begin
            @(posedge rd_clk);
            n++;
        end
        repeat (2) @(posedge rd_clk);
        #1 flush = 1'b1;
        @(posedge rd_clk);
        #1 flush = 1'b0;
        wait_done("F0");
        chk("fd_after_flush", 64'(fd_seen), 64'd4);
        load_burst(28'h400, BL, BL, 32'hA0, BL);
        wait_done("F1");
        chk("fd_after_post_flush", 64'(fd_seen), 64'd4);
        // Flush with nothing staged is ignored
        flush = 1'b1;
        @(posedge rd_clk);
        #1 flush = 1'b0;
        repeat (4) @(posedge rd_clk);
        #1;
        chk("empty_flush_no_req", 64'(burst_req), 64'd0);
`endif

        chk("end_req_queue_empty",  64'(exp_addr.size()), 64'd0);
        chk("end_data_queue_empty", 64'(exp_wd.size()),   64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
